// File: rtl/aes_pkg.sv
// Shared AES datapath constants, drain FSM state type and word-select helper.
package aes_pkg;
  localparam int unsigned AES_BLOCK_W       = 128;
  localparam int unsigned AES_WORD_W        = 32;
  localparam int unsigned AES_WORDS_PER_BLK = 4;
  localparam int unsigned WIDX_W            = $clog2(AES_WORDS_PER_BLK);

  typedef logic [WIDX_W-1:0] widx_t;
  localparam widx_t LAST_WIDX = widx_t'(AES_WORDS_PER_BLK - 1);

  typedef enum logic {DRN_IDLE, DRN_SEND} drain_state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [AES_WORD_W-1:0] word_sel(input logic [AES_BLOCK_W-1:0] blk,
                                                     input widx_t idx);
    return blk[AES_BLOCK_W - 1 - AES_WORD_W*idx -: AES_WORD_W];
  endfunction
endpackage

// File: rtl/aes_ct_drain_if.sv
// Engine-side capture and host-side word stream of the ciphertext drain.
interface aes_ct_drain_if #(
  parameter int unsigned DEPTH = 4
) ();
  import aes_pkg::*;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                   flush;
  logic                   issue;
  logic [AES_BLOCK_W-1:0] in_block;
  logic                   in_valid;
  logic                   credit;
  logic [AES_WORD_W-1:0]  dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;
  logic [CW-1:0]          fifo_count;
  logic                   err;
  logic                   err_clr;

  modport master (
    output flush, issue, in_block, in_valid, dout_ready, err_clr,
    input  credit, dout, dout_valid, dout_last, fifo_count, err
  );

  modport slave (
    input  flush, issue, in_block, in_valid, dout_ready, err_clr,
    output credit, dout, dout_valid, dout_last, fifo_count, err
  );
endinterface

// File: rtl/aes_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module aes_sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/aes_ct_drain.sv
// Buffers AES ciphertext blocks and serialises them MSW-first as 32-bit words, with issue credit.
module aes_ct_drain
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  aes_ct_drain_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] INFL_MAX = '1;

  drain_state_t           state_q, state_d;
  widx_t                  widx_q, widx_d;
  logic [AES_BLOCK_W-1:0] hold_q, hold_d;
  logic [AES_WORD_W-1:0]  dout_q, dout_d;
  logic                   dv_q, dv_d;
  logic                   last_q, last_d;
  logic [CW-1:0]          infl_q, infl_d;
  logic                   err_q, err_d;

  logic                   f_push, f_pop, f_full, f_empty;
  logic [AES_BLOCK_W-1:0] f_rdata;
  logic [CW-1:0]          f_count;
  logic                   hs, drop, unexp;
  logic [CW:0]            occ;

  aes_sync_fifo #(.WIDTH(AES_BLOCK_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (bus.in_block),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign f_push = bus.in_valid & ~bus.flush;
  assign hs     = dv_q & bus.dout_ready;
  assign drop   = f_push & f_full & ~f_pop;
  assign unexp  = f_push & (infl_q == '0);

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    hold_d  = hold_q;
    f_pop   = 1'b0;
    if (bus.flush) begin
      state_d = DRN_IDLE;
      widx_d  = '0;
    end else begin
      unique case (state_q)
        DRN_IDLE: begin
          if (!f_empty) begin
            f_pop   = 1'b1;
            hold_d  = f_rdata;
            widx_d  = '0;
            state_d = DRN_SEND;
          end
        end
        DRN_SEND: begin
          if (hs) begin
            if (widx_q == LAST_WIDX) begin
              widx_d = '0;
              if (!f_empty) begin
                f_pop  = 1'b1;
                hold_d = f_rdata;
              end else begin
                state_d = DRN_IDLE;
              end
            end else begin
              widx_d = widx_q + widx_t'(1);
            end
          end
        end
      endcase
    end
    // Output word is registered from the next hold/index so dout is held during a stall.
    dv_d   = (state_d == DRN_SEND);
    dout_d = dv_d ? word_sel(hold_d, widx_d) : '0;
    last_d = dv_d && (widx_d == LAST_WIDX);
  end

  always_comb begin
    infl_d = infl_q;
    if (bus.flush) begin
      infl_d = '0;
    end else if (bus.issue && !bus.in_valid) begin
      if (infl_q != INFL_MAX) infl_d = infl_q + CW'(1);
    end else if (!bus.issue && bus.in_valid) begin
      if (infl_q != '0) infl_d = infl_q - CW'(1);
    end
    err_d = (err_q & ~bus.err_clr) | drop | unexp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRN_IDLE;
      widx_q  <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      infl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      infl_q  <= infl_d;
      err_q   <= err_d;
    end
  end

  // The block in the hold register still occupies a slot until its last word leaves.
  assign occ = {1'b0, f_count} + {1'b0, infl_q} + (CW+1)'(state_q == DRN_SEND);

  assign bus.credit     = (occ < (CW+1)'(DEPTH));
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.dout_last  = last_q;
  assign bus.fifo_count = f_count;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_aes_ct_drain.sv
// Bench for aes_ct_drain: queue-based reference model checked every cycle plus directed literals.
module tb_aes_ct_drain;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int          INFL_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_ct_drain_if #(.DEPTH(DEPTH)) bus ();
  aes_ct_drain #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of blocks, queue of words still to be sent from the current block.
  logic [127:0] fq[$];
  logic [31:0]  hq[$];
  logic [127:0] m_blk;
  int           m_infl;
  bit           m_err, m_evt, m_hs, m_pop;
  int           m_nf, m_nh, m_occ;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete(); hq.delete(); m_infl = 0; m_err = 0;
    end else begin
      m_evt = 0;
      if (bus.flush) begin
        fq.delete(); hq.delete(); m_infl = 0;
      end else begin
        m_nf  = fq.size();
        m_nh  = hq.size();
        m_hs  = (m_nh > 0) && bus.dout_ready;
        m_pop = (m_nf > 0) && ((m_nh == 0) || (m_hs && m_nh == 1));
        if (bus.in_valid && m_infl == 0) m_evt = 1;
        if (m_hs) void'(hq.pop_front());
        if (m_pop) begin
          m_blk = fq.pop_front();
          for (int k = 0; k < 4; k++) hq.push_back(32'(m_blk >> (96 - 32*k)));
        end
        if (bus.in_valid) begin
          if (m_nf < DEPTH || m_pop) fq.push_back(bus.in_block);
          else m_evt = 1;
        end
        if (bus.issue && !bus.in_valid && m_infl < INFL_MAX) m_infl++;
        else if (!bus.issue && bus.in_valid && m_infl > 0) m_infl--;
      end
      m_err = (m_err && !bus.err_clr) || m_evt;
    end
  end

  always @(negedge clk) begin
    m_occ = fq.size() + m_infl + ((hq.size() > 0) ? 1 : 0);
    chk("m_dout_valid", 128'(bus.dout_valid), 128'(hq.size() > 0));
    if (hq.size() > 0) begin
      chk("m_dout", 128'(bus.dout), 128'(hq[0]));
      chk("m_dout_last", 128'(bus.dout_last), 128'(hq.size() == 1));
    end
    chk("m_fifo_count", 128'(bus.fifo_count), 128'(fq.size()));
    chk("m_credit", 128'(bus.credit), 128'(m_occ < DEPTH));
    chk("m_err", 128'(bus.err), 128'(m_err));
  end

  logic [127:0] ablk [6];
  logic [31:0]  w5   [8];

  initial begin
    ablk[0] = 128'hA0000000_A0000001_A0000002_A0000003;
    ablk[1] = 128'hA1000000_A1000001_A1000002_A1000003;
    ablk[2] = 128'hA2000000_A2000001_A2000002_A2000003;
    ablk[3] = 128'hA3000000_A3000001_A3000002_A3000003;
    ablk[4] = 128'hA4000000_A4000001_A4000002_A4000003;
    ablk[5] = 128'hA5000000_A5000001_A5000002_A5000003;
    w5 = '{32'h01000000, 32'h01000001, 32'h01000002, 32'h01000003,
           32'h02000000, 32'h02000001, 32'h02000002, 32'h02000003};

    bus.flush = 0; bus.issue = 0; bus.in_valid = 0; bus.in_block = '0;
    bus.dout_ready = 0; bus.err_clr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 128'(bus.dout), 128'h0);
    chk("rst_dout_valid", 128'(bus.dout_valid), 128'h0);
    chk("rst_fifo_count", 128'(bus.fifo_count), 128'h0);
    chk("rst_credit", 128'(bus.credit), 128'h1);
    chk("rst_err", 128'(bus.err), 128'h0);
    #1 rst_n = 1'b1;
    step();

    // 1: single block, words at t+2..t+5
    bus.dout_ready = 1;
    bus.issue = 1; step(); bus.issue = 0;
    bus.in_valid = 1; bus.in_block = 128'h00112233_44556677_8899AABB_CCDDEEFF; step();
    bus.in_valid = 0;
    @(negedge clk);
    chk("t1_not_yet_valid", 128'(bus.dout_valid), 128'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", 128'(bus.dout_valid), 128'h1);
      chk("t1_last", 128'(bus.dout_last), 128'(k == 3));
      case (k)
        0: chk("t1_w0", 128'(bus.dout), 128'h00112233);
        1: chk("t1_w1", 128'(bus.dout), 128'h44556677);
        2: chk("t1_w2", 128'(bus.dout), 128'h8899AABB);
        default: chk("t1_w3", 128'(bus.dout), 128'hCCDDEEFF);
      endcase
    end
    step(); step();

    // 2: four issues exhaust credit; four blocks -> three queued plus one held
    bus.dout_ready = 0;
    repeat (4) begin bus.issue = 1; step(); end
    bus.issue = 0;
    @(negedge clk);
    chk("t2_credit_after_4", 128'(bus.credit), 128'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in_block = ablk[i]; step();
    end
    bus.in_valid = 0;
    @(negedge clk);
    chk("t2_fifo_count", 128'(bus.fifo_count), 128'd3);
    chk("t2_err", 128'(bus.err), 128'h0);
    chk("t2_head_word", 128'(bus.dout), 128'hA0000000);
    step();

    // 3: fill to DEPTH, then an overflow drop sets err; err_clr clears it
    bus.issue = 1; step(); bus.issue = 0;
    bus.in_valid = 1; bus.in_block = ablk[4]; step(); bus.in_valid = 0;
    @(negedge clk);
    chk("t3_full_count", 128'(bus.fifo_count), 128'd4);
    chk("t3_err_before", 128'(bus.err), 128'h0);
    step();
    bus.issue = 1; step(); bus.issue = 0;
    bus.in_valid = 1; bus.in_block = ablk[5]; step(); bus.in_valid = 0;
    @(negedge clk);
    chk("t3_count_after_drop", 128'(bus.fifo_count), 128'd4);
    chk("t3_err_drop", 128'(bus.err), 128'h1);
    step();
    bus.err_clr = 1; step(); bus.err_clr = 0;
    @(negedge clk);
    chk("t3_err_cleared", 128'(bus.err), 128'h0);
    step();

    // 4: ready pattern 1,0,0,1 advances exactly two words
    bus.dout_ready = 1; step();
    bus.dout_ready = 0; step(); step();
    bus.dout_ready = 1; step();
    bus.dout_ready = 0;
    @(negedge clk);
    chk("t4_word2", 128'(bus.dout), 128'hA0000002);
    chk("t4_valid", 128'(bus.dout_valid), 128'h1);
    step();
    bus.dout_ready = 1;
    repeat (24) step();
    @(negedge clk);
    chk("t4_drained_valid", 128'(bus.dout_valid), 128'h0);
    chk("t4_drained_count", 128'(bus.fifo_count), 128'd0);
    step();

    // 5: two back-to-back blocks stream 8 words with no gap
    bus.issue = 1; step(); step(); bus.issue = 0;
    bus.in_valid = 1; bus.in_block = 128'h01000000_01000001_01000002_01000003; step();
    bus.in_block = 128'h02000000_02000001_02000002_02000003; step();
    bus.in_valid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_valid", 128'(bus.dout_valid), 128'h1);
      chk("t5_word", 128'(bus.dout), 128'(w5[k]));
      chk("t5_last", 128'(bus.dout_last), 128'((k == 3) || (k == 7)));
    end
    step(); step();

    // 6: flush while showing word 2 with two blocks queued; err (set by unexpected block) survives
    bus.dout_ready = 0;
    bus.issue = 1; step(); step(); bus.issue = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_block = ablk[i]; step();
    end
    bus.in_valid = 0;
    @(negedge clk);
    chk("t6_queued", 128'(bus.fifo_count), 128'd2);
    chk("t6_err_unexpected", 128'(bus.err), 128'h1);
    step();
    bus.dout_ready = 1; step(); step();
    bus.dout_ready = 0; bus.flush = 1;
    @(negedge clk);
    chk("t6_word2_before_flush", 128'(bus.dout), 128'hA0000002);
    step();
    bus.flush = 0;
    @(negedge clk);
    chk("t6_flush_valid", 128'(bus.dout_valid), 128'h0);
    chk("t6_flush_count", 128'(bus.fifo_count), 128'd0);
    chk("t6_flush_credit", 128'(bus.credit), 128'h1);
    chk("t6_flush_err", 128'(bus.err), 128'h1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
